rgb_frame_reader: RTL and testbench

- Downstream consumer of the colourspace-conversion stage. Reads the packed RGB frame that stage writes to SRAM (base 146944) and unpacks 16-bit words into 24-bit pixels.
- Delivers pixels in raster order to the VGA display path through a valid/ready handshake, buffering them in a small FIFO.
- Owns the SRAM port only between `start` and `done`; read-only.

---
 rtl/rgb_frame_reader_pkg.sv | 22 ++
 rtl/rgb_frame_reader_fifo.sv | 65 ++++++
 rtl/rgb_frame_reader.sv | 225 ++++++++++++++++++++++
 tb/tb_rgb_frame_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_frame_reader_pkg.sv
// Shared definitions for the RGB frame path: reader FSM states, frame placement
// in SRAM and the unpacked pixel type.
package rgb_frame_reader_pkg;

  typedef enum logic [2:0] {
    S_RFR_IDLE,
    S_RFR_ISSUE_0,
    S_RFR_ISSUE_1,
    S_RFR_ISSUE_2,
    S_RFR_DRAIN
  } rfr_state_type;

  localparam logic [17:0] RGB_BASE_ADDR = 18'd146944;
  localparam int          FRAME_PIXELS  = 76800;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pixel_t;

endpackage

// File: rtl/rgb_frame_reader_fifo.sv
// Small pixel FIFO whose head entry is held in a register, so the head stays
// stable (and keeps its last value) while the FIFO is empty.
module rgb_pixel_fifo
  import rgb_frame_reader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  rgb_pixel_t               din,
  input  logic                     pop,
  output rgb_pixel_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rgb_pixel_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;
  logic          pop_ok;

  assign empty       = (count == CW'(0));
  assign full        = (count == CW'(DEPTH));
  assign pop_ok      = pop && !empty;
  assign rd_ptr_next = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_next;
      end
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Next head comes straight from din when the FIFO is (or becomes) empty
      if (push && (empty || (pop_ok && count == CW'(1)))) begin
        head <= din;
      end else if (pop_ok && count > CW'(1)) begin
        head <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/rgb_frame_reader.sv
// Reads the packed RGB frame from SRAM (3 words per pixel pair) and streams
// 24-bit pixels in raster order through a credit-protected FIFO.
//   state         | meaning
//   S_RFR_IDLE    | SRAM not owned, waiting for start
//   S_RFR_ISSUE_0 | issue w0 once FIFO credit covers the whole pair
//   S_RFR_ISSUE_1 | issue w1
//   S_RFR_ISSUE_2 | issue w2, then next group or drain
//   S_RFR_DRAIN   | all words issued, wait for last pixel pop
module rgb_frame_reader
  import rgb_frame_reader_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR    = RGB_BASE_ADDR,
  parameter int          NUM_PIXELS   = FRAME_PIXELS,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          SRAM_LATENCY = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic [7:0]  pixel_R,
  output logic [7:0]  pixel_G,
  output logic [7:0]  pixel_B,
  output logic        pixel_last
);
  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int          CRW        = CW + 1;
  localparam logic [17:0] LAST_ADDR  = BASE_ADDR + 18'(3 * NUM_PIXELS / 2 - 1);
  localparam logic [16:0] LAST_GROUP = 17'(NUM_PIXELS / 2 - 1);
  localparam logic [16:0] LAST_PIXEL = 17'(NUM_PIXELS - 1);

  rfr_state_type state;
  rfr_state_type next_state;

  logic                         start_ok;
  logic                         issue;
  logic [1:0]                   issue_phase;
  logic                         credit_ok;
  logic [17:0]                  addr;
  logic [16:0]                  groups_issued;
  logic [16:0]                  out_idx;
  logic [CW-1:0]                pending;
  logic [CW-1:0]                fifo_count;
  logic [SRAM_LATENCY-1:0]      tag_valid;
  logic [SRAM_LATENCY-1:0][1:0] tag_phase;
  logic                         cap_valid;
  logic [1:0]                   cap_phase;
  logic [7:0]                   r0;
  logic [7:0]                   g0;
  logic [7:0]                   r1;
  logic                         push;
  logic                         pop;
  logic                         fifo_empty;
  logic                         fifo_full;
  logic                         done_q;
  rgb_pixel_t                   push_pixel;
  rgb_pixel_t                   head;

  // A group is only started when the FIFO can absorb both of its pixels
  assign credit_ok = (CRW'(fifo_count) + CRW'(pending) + CRW'(2)) <= CRW'(FIFO_DEPTH);

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_RFR_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    start_ok    = 1'b0;
    issue       = 1'b0;
    issue_phase = 2'd0;
    case (state)
      S_RFR_IDLE: begin
        if (start && !done_q) begin
          start_ok   = 1'b1;
          next_state = S_RFR_ISSUE_0;
        end
      end
      S_RFR_ISSUE_0: begin
        if (credit_ok) begin
          issue      = 1'b1;
          next_state = S_RFR_ISSUE_1;
        end
      end
      S_RFR_ISSUE_1: begin
        issue       = 1'b1;
        issue_phase = 2'd1;
        next_state  = S_RFR_ISSUE_2;
      end
      S_RFR_ISSUE_2: begin
        issue       = 1'b1;
        issue_phase = 2'd2;
        next_state  = (groups_issued == LAST_GROUP) ? S_RFR_DRAIN : S_RFR_ISSUE_0;
      end
      S_RFR_DRAIN: begin
        if (pop && pixel_last) begin
          next_state = S_RFR_IDLE;
        end
      end
      default: next_state = S_RFR_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      addr          <= BASE_ADDR;
      groups_issued <= '0;
      out_idx       <= '0;
      pending       <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q  <= (state == S_RFR_DRAIN) && pop && pixel_last;
      pending <= pending + ((issue && issue_phase == 2'd0) ? CW'(2) : CW'(0))
                         - (push ? CW'(1) : CW'(0));
      if (start_ok) begin
        addr          <= BASE_ADDR;
        groups_issued <= '0;
        out_idx       <= '0;
      end else begin
        // Holding at the top word keeps the address from ever wrapping
        if (issue && addr != LAST_ADDR) begin
          addr <= addr + 18'd1;
        end
        if (issue && issue_phase == 2'd2) begin
          groups_issued <= groups_issued + 17'd1;
        end
        if (pop) begin
          out_idx <= out_idx + 17'd1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      tag_valid <= '0;
      tag_phase <= '0;
    end else begin
      tag_valid[0] <= issue;
      tag_phase[0] <= issue_phase;
      for (int i = 1; i < SRAM_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_phase[i] <= tag_phase[i-1];
      end
    end
  end

  assign cap_valid = tag_valid[SRAM_LATENCY-1];
  assign cap_phase = tag_phase[SRAM_LATENCY-1];

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r0 <= '0;
      g0 <= '0;
      r1 <= '0;
    end else if (cap_valid) begin
      if (cap_phase == 2'd0) begin
        r0 <= SRAM_read_data[15:8];
        g0 <= SRAM_read_data[7:0];
      end else if (cap_phase == 2'd1) begin
        r1 <= SRAM_read_data[7:0];
      end
    end
  end

  always_comb begin
    push       = 1'b0;
    push_pixel = '0;
    if (cap_valid) begin
      case (cap_phase)
        2'd1: begin
          push       = 1'b1;
          push_pixel = {r0, g0, SRAM_read_data[15:8]};
        end
        2'd2: begin
          push       = 1'b1;
          push_pixel = {r1, SRAM_read_data[15:8], SRAM_read_data[7:0]};
        end
        default: begin
          push       = 1'b0;
          push_pixel = '0;
        end
      endcase
    end
  end

  rgb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50_I),
    .rst_n (Resetn),
    .push  (push),
    .din   (push_pixel),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  fifo_no_overflow: assert property (
    @(posedge CLOCK_50_I) disable iff (!Resetn) !(push && fifo_full && !pop)
  );

  assign pixel_valid  = !fifo_empty;
  assign pop          = pixel_valid && pixel_ready;
  assign pixel_R      = head.r;
  assign pixel_G      = head.g;
  assign pixel_B      = head.b;
  assign pixel_last   = pixel_valid && (out_idx == LAST_PIXEL);
  assign busy         = (state != S_RFR_IDLE);
  assign done         = done_q;
  assign SRAM_address = addr;
  assign SRAM_we_n    = 1'b1;

endmodule

// File: tb/tb_rgb_frame_reader.sv
// Directed bench for rgb_frame_reader on a compact 32-pixel frame placed so its
// last word sits at the top of SRAM (262143); SRAM is modelled with 2-cycle latency.
module tb_rgb_frame_reader;
  localparam int          NP   = 32;
  localparam int          NW   = 48;
  localparam logic [17:0] BASE = 18'd262096;
  localparam logic [17:0] LAST = 18'd262143;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        pixel_ready = 1'b0;
  logic        busy, done, we_n, pixel_valid, pixel_last;
  logic [17:0] addr;
  logic [15:0] rdata;
  logic [7:0]  pr, pg, pb;

  always #10 clk = ~clk;

  rgb_frame_reader #(
    .BASE_ADDR    (BASE),
    .NUM_PIXELS   (NP),
    .FIFO_DEPTH   (8),
    .SRAM_LATENCY (2)
  ) dut (
    .CLOCK_50_I     (clk),
    .Resetn         (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .SRAM_address   (addr),
    .SRAM_we_n      (we_n),
    .SRAM_read_data (rdata),
    .pixel_valid    (pixel_valid),
    .pixel_ready    (pixel_ready),
    .pixel_R        (pr),
    .pixel_G        (pg),
    .pixel_B        (pb),
    .pixel_last     (pixel_last)
  );

  logic [15:0] words [NW];
  logic [15:0] d1 = '0;
  logic [15:0] d2 = '0;

  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    int idx;
    idx = int'(a) - int'(BASE);
    if (idx >= 0 && idx < NW) return words[idx];
    return 16'hdead;
  endfunction

  always @(posedge clk) begin
    d1 <= mem_rd(addr);
    d2 <= d1;
  end
  assign rdata = d2;

  logic [24:0] got [$];
  int          done_cnt = 0;
  int          oob_cnt = 0;
  logic [17:0] max_addr = '0;

  always @(negedge clk) begin
    if (pixel_valid && pixel_ready) got.push_back({pixel_last, pr, pg, pb});
    if (done) done_cnt <= done_cnt + 1;
    if (busy && (addr < BASE || addr > LAST)) oob_cnt <= oob_cnt + 1;
    if (busy && addr > max_addr) max_addr <= addr;
  end

  function automatic logic [23:0] exp_pix(input int p);
    int k;
    k = p / 2;
    if (p % 2 == 0) return {words[3*k], words[3*k+1][15:8]};
    return {words[3*k+1][7:0], words[3*k+2]};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) words[i] = 16'($urandom);
  endtask

  task automatic check_frame(input string tag);
    int bad;
    int lastbad;
    bad = 0;
    lastbad = 0;
    chk({tag, " pixel count"}, 32'(got.size()), 32'(NP));
    for (int i = 0; i < got.size() && i < NP; i++) begin
      if (got[i][23:0] !== exp_pix(i)) bad++;
      if (got[i][24] !== (i == NP - 1)) lastbad++;
    end
    chk({tag, " pixel data mismatches"}, 32'(bad), 32'd0);
    chk({tag, " pixel_last misplaced"}, 32'(lastbad), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    chk({tag, " done seen"}, 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    int run;
    logic [17:0] a40;

    for (int i = 0; i < NW; i++) words[i] = 16'(i * 16'h0101) ^ 16'h5a5a;
    words[0] = 16'h1122;
    words[1] = 16'h3344;
    words[2] = 16'h5566;

    #5 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset pixel_valid", 32'(pixel_valid), 32'd0);
    chk("reset pixel_last", 32'(pixel_last), 32'd0);
    chk("reset pixel rgb", 32'({pr, pg, pb}), 32'd0);
    chk("reset SRAM_address", 32'(addr), 32'(BASE));
    chk("reset SRAM_we_n", 32'(we_n), 32'd1);
    rst_n = 1'b1;
    tick();

    // Single pair data, consumer always ready; check latency and done timing
    got.delete();
    d0 = done_cnt;
    pixel_ready = 1'b1;
    start = 1'b1;
    n = 0;
    do begin
      tick();
      start = 1'b0;
      n++;
    end while (!pixel_valid && n < 20);
    chk("first pixel_valid latency", 32'(n), 32'd5);
    chk("first pixel rgb", 32'({pr, pg, pb}), 32'h112233);
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("done cycle after start", 32'(n), 32'(3 * NP / 2 + 4));
    chk("busy low with done", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start during done ignored", 32'(busy), 32'd0);
    tick();
    chk("still idle after ignored start", 32'(busy), 32'd0);
    chk("second pixel rgb", 32'(got.size() > 1 ? got[1][23:0] : 24'hxxxxxx), 32'h445566);
    check_frame("pair");
    chk("done pulses once", 32'(done_cnt - d0), 32'd1);
    chk("highest address read", 32'(max_addr), 32'(LAST));
    chk("address out of range", 32'(oob_cnt), 32'd0);

    // Backpressure: consumer stalled, issue must freeze on credits
    fill_random();
    got.delete();
    pixel_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (39) tick();
    a40 = addr;
    repeat (10) tick();
    chk("stall address stable", 32'(addr), 32'(a40));
    chk("stall address value", 32'(addr), 32'(BASE + 18'd12));
    chk("stall pixel_valid", 32'(pixel_valid), 32'd1);
    chk("stall head pixel", 32'({pr, pg, pb}), 32'(exp_pix(0)));
    chk("stall busy", 32'(busy), 32'd1);
    pixel_ready = 1'b1;
    run = 0;
    for (int i = 0; i < 8; i++) begin
      if (pixel_valid) run++;
      tick();
    end
    chk("drain without gap", 32'(run), 32'd8);
    wait_done("stall", 300);
    check_frame("stall");

    // Random backpressure with a start pulse while busy
    fill_random();
    got.delete();
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 3000) begin
      pixel_ready = 1'($urandom_range(0, 1));
      start = (n == 20);
      tick();
      n++;
    end
    start = 1'b0;
    chk("random done seen", 32'(done), 32'd1);
    tick();
    check_frame("random");
    chk("random done pulses once", 32'(done_cnt - d0), 32'd1);
    chk("random address out of range", 32'(oob_cnt), 32'd0);

    // Reset in the middle of a frame, then a clean frame
    pixel_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset pixel_valid", 32'(pixel_valid), 32'd0);
    chk("midreset SRAM_address", 32'(addr), 32'(BASE));
    chk("midreset SRAM_we_n", 32'(we_n), 32'd1);
    chk("midreset done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fill_random();
    got.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("post reset", 300);
    check_frame("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
